// File: rtl/mul_issue_queue_pkg.sv
// Shared constants and helpers for the multiplier issue queue and its bench.
//   OP_W / RES_W    : operand and product widths of the Booth/CSA multiplier
//   *_DEF           : default tag width, multiplier latency and response depth
//   res_ovf()       : product does not fit in the low operand-width bits
package mul_issue_queue_pkg;

  localparam int OP_W           = 32;
  localparam int RES_W          = 64;
  localparam int MUL_LAT_DEF    = 2;
  localparam int TAG_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [RES_W-1:0] res_t;

  function automatic logic res_ovf(input res_t res);
    return |res[RES_W-1:OP_W];
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// Synchronous response FIFO holding {ovf, tag, res} entries.
//   clk, reset : clock, synchronous active-low reset (clears pointers only)
//   push, din  : write one entry; caller never pushes when full
//   pop, dout  : dout shows the head entry; pop retires it
//   full/empty : occupancy flags
module mul_rsp_fifo
  import mul_issue_queue_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;

  // DEPTH is a power of two, so the pointers wrap on their own.
  assign do_pop = pop & ~empty;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mul_issue_queue.sv
// Front-end sequencer for the 32x32 multiplier.
//   req_*   : valid/ready request channel with operands and tag
//   mul_*   : issue strobe and registered operands out, product and valid in
//   rsp_*   : in-order valid/ready response channel {res, tag, ovf}
//   busy    : any accepted op not yet popped
//   err     : sticky, multiplier valid was low at a capture cycle
// A credit counter bounds accepted-but-not-popped ops to the FIFO depth, so a
// product arriving MUL_LAT cycles after issue always has a slot waiting.
module mul_issue_queue
  import mul_issue_queue_pkg::*;
#(
  parameter int TAG_W      = TAG_W_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op1,
  input  logic [OP_W-1:0]  req_op2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_en,
  output logic [OP_W-1:0]  mul_op1,
  output logic [OP_W-1:0]  mul_op2,
  input  logic [RES_W-1:0] mul_res,
  input  logic             mul_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_res,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_ovf,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 1 + TAG_W + RES_W;

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             pop;
  logic             capture;
  logic [TAG_W-1:0] tag_p0;
  logic [MUL_LAT:1] vld_p;
  logic [TAG_W-1:0] tag_p [1:MUL_LAT];
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] fifo_din;
  logic [ENT_W-1:0] fifo_dout;

  assign req_ready = reset & (cnt < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (cnt != '0);

  // Stage p0: issue registers; mul_en is the valid of this stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      mul_en  <= 1'b0;
      mul_op1 <= '0;
      mul_op2 <= '0;
    end else begin
      mul_en <= accept;
      if (accept) begin
        mul_op1 <= req_op1;
        mul_op2 <= req_op2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_p0 <= req_tag;
  end

  // Stages p1..pMUL_LAT: tag pipe shadowing the multiplier, advances every cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[1] <= mul_en;
      for (int k = 2; k <= MUL_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[1] <= tag_p0;
    for (int k = 2; k <= MUL_LAT; k++) tag_p[k] <= tag_p[k-1];
  end

  // Capture: product and tag land in the response FIFO
  assign capture   = vld_p[MUL_LAT];
  // The credit counter already keeps the FIFO from filling; the gate is defensive.
  assign fifo_push = capture & ~fifo_full;
  assign fifo_din  = {res_ovf(mul_res), tag_p[MUL_LAT], mul_res};

  always_ff @(posedge clk) begin
    if (!reset)                 err <= 1'b0;
    else if (capture && !mul_val) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  mul_rsp_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_ovf = fifo_dout[ENT_W-1];
  assign rsp_tag = fifo_dout[RES_W +: TAG_W];
  assign rsp_res = fifo_dout[RES_W-1:0];

endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue: a behavioural multiplier stub feeds mul_res, and
// an in-order queue of expected {ovf, tag, product} entries is built from the
// accepted requests and compared against the popped responses.
module tb_mul_issue_queue;
  import mul_issue_queue_pkg::*;

  localparam int TAG_W = TAG_W_DEF;
  localparam int LAT   = MUL_LAT_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;
  localparam int ENT_W = 1 + TAG_W + RES_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op1;
  logic [OP_W-1:0]  req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             mul_en;
  logic [OP_W-1:0]  mul_op1;
  logic [OP_W-1:0]  mul_op2;
  logic [RES_W-1:0] mul_res;
  logic             mul_val;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_ovf;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  mul_issue_queue #(.TAG_W(TAG_W), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .mul_en(mul_en), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_res(mul_res), .mul_val(mul_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_tag(rsp_tag), .rsp_ovf(rsp_ovf),
    .busy(busy), .err(err)
  );

  // Multiplier stub: product is valid LAT cycles after the mul_en cycle.
  logic [RES_W-1:0] m_res [LAT];
  logic [LAT-1:0]   m_vld;
  logic             kill_val = 1'b0;

  always @(posedge clk) begin
    if (!reset) m_vld <= '0;
    else begin
      m_vld[0] <= mul_en;
      for (int k = 1; k < LAT; k++) m_vld[k] <= m_vld[k-1];
    end
    m_res[0] <= RES_W'(mul_op1) * RES_W'(mul_op2);
    for (int k = 1; k < LAT; k++) m_res[k] <= m_res[k-1];
  end

  assign mul_res = m_res[LAT-1];
  assign mul_val = m_vld[LAT-1] & ~kill_val;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] got_q[$];
  int               acc_cyc[$];
  int               got_cyc[$];
  int               n_chk = 0;
  int               n_pass = 0;
  int               n_fail = 0;

  function automatic logic [ENT_W-1:0] model_entry(input logic [TAG_W-1:0] tag,
                                                   input logic [OP_W-1:0] a,
                                                   input logic [OP_W-1:0] b);
    logic [RES_W-1:0] p;
    p = RES_W'(a) * RES_W'(b);
    return {(p >= 65'h1_0000_0000), tag, p};
  endfunction

  // One clock cycle: record handshakes seen this cycle, then move to next negedge.
  task automatic step();
    #1;
    if (req_valid && req_ready) begin
      exp_q.push_back(model_entry(req_tag, req_op1, req_op2));
      acc_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_ovf, rsp_tag, rsp_res});
      got_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic clear_rec();
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
  endtask

  task automatic drain(input int budget, output bit ok);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_op1 = 32'd9; req_op2 = 32'd9; req_tag = '1;
    rsp_ready = 1'b1;
    step(); step();
    n_chk++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL reset_mul_en got %b want 0", mul_en); end else n_pass++;
    n_chk++; if (mul_op1 !== '0) begin n_fail++; $display("FAIL reset_mul_op1 got %h want 0", mul_op1); end else n_pass++;
    n_chk++; if (mul_op2 !== '0) begin n_fail++; $display("FAIL reset_mul_op2 got %h want 0", mul_op2); end else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end else n_pass++;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end else n_pass++;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end else n_pass++;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end else n_pass++;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", req_ready); end else n_pass++;
    @(negedge clk);
    clear_rec();
  endtask

  task automatic test_single();
    bit ok;
    clear_rec();
    rsp_ready = 1'b1; req_valid = 1'b1; req_op1 = 32'd3; req_op2 = 32'd5; req_tag = TAG_W'(1);
    step();
    req_valid = 1'b0; req_op1 = $urandom; req_op2 = $urandom;
    n_chk++; if (mul_en !== 1'b1) begin n_fail++; $display("FAIL single_mul_en got %b want 1", mul_en); end else n_pass++;
    n_chk++; if ({mul_op1, mul_op2} !== {32'd3, 32'd5}) begin n_fail++; $display("FAIL single_ops got %h/%h want 3/5", mul_op1, mul_op2); end else n_pass++;
    step();
    n_chk++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL single_mul_en_pulse got %b want 0", mul_en); end else n_pass++;
    n_chk++; if ({mul_op1, mul_op2} !== {32'd3, 32'd5}) begin n_fail++; $display("FAIL single_ops_hold got %h/%h want 3/5", mul_op1, mul_op2); end else n_pass++;
    drain(20, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_drain got timeout want idle"); end else n_pass++;
    n_chk++; if (got_q.size() !== 1 || acc_cyc.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d rsp %0d acc want 1", got_q.size(), acc_cyc.size()); end else n_pass++;
    if (got_q.size() > 0 && acc_cyc.size() > 0) begin
      n_chk++; if (got_q[0] !== {1'b0, TAG_W'(1), 64'd15}) begin n_fail++; $display("FAIL single_rsp got %h want 15 tag 1 ovf 0", got_q[0]); end else n_pass++;
      n_chk++; if (got_cyc[0] - acc_cyc[0] !== 2 + LAT) begin n_fail++; $display("FAIL single_latency got %0d want %0d", got_cyc[0] - acc_cyc[0], 2 + LAT); end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [63:0] want [4];
    want[0] = 64'd2; want[1] = 64'd6; want[2] = 64'd12; want[3] = 64'd20;
    clear_rec();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op1 = 32'(i + 1); req_op2 = 32'(i + 2); req_tag = TAG_W'(i);
      step();
    end
    drain(20, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got timeout want idle"); end else n_pass++;
    n_chk++; if (got_q.size() !== 4 || acc_cyc.size() !== 4) begin n_fail++; $display("FAIL b2b_count got %0d rsp %0d acc want 4", got_q.size(), acc_cyc.size()); end else n_pass++;
    for (int i = 0; i < 4 && i < got_q.size() && acc_cyc.size() == 4; i++) begin
      n_chk++; if (got_q[i][RES_W-1:0] !== want[i]) begin n_fail++; $display("FAIL b2b_res%0d got %0d want %0d", i, got_q[i][RES_W-1:0], want[i]); end else n_pass++;
      n_chk++; if (got_q[i][RES_W +: TAG_W] !== TAG_W'(i)) begin n_fail++; $display("FAIL b2b_tag%0d got %0d want %0d", i, got_q[i][RES_W +: TAG_W], i); end else n_pass++;
      n_chk++; if (got_cyc[i] !== acc_cyc[0] + 2 + LAT + i) begin n_fail++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, got_cyc[i], acc_cyc[0] + 2 + LAT + i); end else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int sent;
    logic [OP_W-1:0] a [6];
    logic [OP_W-1:0] b [6];
    clear_rec();
    for (int i = 0; i < 6; i++) begin
      a[i] = $urandom;
      b[i] = $urandom_range(1, 1000);
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      sent = acc_cyc.size();
      req_valid = 1'b1; req_op1 = a[sent]; req_op2 = b[sent]; req_tag = TAG_W'(sent);
      step();
    end
    n_chk++; if (acc_cyc.size() !== DEPTH) begin n_fail++; $display("FAIL bp_accepted got %0d want %0d", acc_cyc.size(), DEPTH); end else n_pass++;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", req_ready); end else n_pass++;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", busy); end else n_pass++;
    for (int c = 0; c < 2 && exp_q.size() > 0; c++) begin
      n_chk++; if ({rsp_valid, rsp_tag, rsp_res} !== {1'b1, exp_q[0][RES_W +: TAG_W], exp_q[0][RES_W-1:0]})
        begin n_fail++; $display("FAIL bp_stall_head got v%b %0d %h want head %h", rsp_valid, rsp_tag, rsp_res, exp_q[0]); end else n_pass++;
      step();
    end
    // Pop while full: no accept in this cycle, req_ready only on the next one.
    rsp_ready = 1'b1;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %b want 0", req_ready); end else n_pass++;
    step();
    n_chk++; if (got_q.size() !== 1 || acc_cyc.size() !== DEPTH) begin n_fail++; $display("FAIL full_pop_counts got %0d rsp %0d acc want 1/%0d", got_q.size(), acc_cyc.size(), DEPTH); end else n_pass++;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", req_ready); end else n_pass++;
    for (int c = 0; c < 40 && acc_cyc.size() < 6; c++) begin
      sent = acc_cyc.size();
      req_valid = 1'b1; req_op1 = a[sent]; req_op2 = b[sent]; req_tag = TAG_W'(sent);
      step();
    end
    drain(40, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_drain got timeout want idle"); end else n_pass++;
    n_chk++; if (got_q.size() !== 6 || exp_q.size() !== 6) begin n_fail++; $display("FAIL bp_total got %0d rsp %0d acc want 6", got_q.size(), exp_q.size()); end else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rsp%0d got %h want %h", i, got_q[i], exp_q[i]); end else n_pass++;
    end
  endtask

  task automatic test_ovf();
    bit ok;
    clear_rec();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op1 = 32'h0001_0000; req_op2 = 32'h0001_0000; req_tag = TAG_W'(2);
    step();
    req_op1 = 32'h0000_FFFF; req_op2 = 32'h0000_FFFF; req_tag = TAG_W'(3);
    step();
    drain(20, ok);
    n_chk++; if (ok !== 1'b1 || got_q.size() !== 2) begin n_fail++; $display("FAIL ovf_count got %0d rsp ok %b want 2", got_q.size(), ok); end else n_pass++;
    if (got_q.size() == 2) begin
      n_chk++; if (got_q[0] !== {1'b1, TAG_W'(2), 64'h0000_0001_0000_0000}) begin n_fail++; $display("FAIL ovf_big got %h want ovf 1 tag 2 res 100000000", got_q[0]); end else n_pass++;
      n_chk++; if (got_q[1] !== {1'b0, TAG_W'(3), 64'h0000_0000_FFFE_0001}) begin n_fail++; $display("FAIL ovf_small got %h want ovf 0 tag 3 res fffe0001", got_q[1]); end else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_rec();
    for (int c = 0; c < 300; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       begin req_op1 = $urandom_range(0, 255); req_op2 = $urandom_range(0, 255); end
        1:       begin req_op1 = $urandom;               req_op2 = $urandom;               end
        default: begin req_op1 = 32'hFFFF_FFFF;         req_op2 = $urandom;               end
      endcase
      req_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      n_chk++; if (req_ready !== ((exp_q.size() - got_q.size()) < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d got %b outstanding %0d", c, req_ready, exp_q.size() - got_q.size()); end else n_pass++;
      n_chk++; if (busy !== (exp_q.size() != got_q.size())) begin n_fail++; $display("FAIL rnd_busy c%0d got %b outstanding %0d", c, busy, exp_q.size() - got_q.size()); end else n_pass++;
      step();
    end
    drain(60, ok);
    n_chk++; if (ok !== 1'b1 || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_total got %0d rsp want %0d ok %b", got_q.size(), exp_q.size(), ok); end else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_rsp%0d got %h want %h", i, got_q[i], exp_q[i]); end else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    clear_rec();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op1 = 32'd11; req_op2 = 32'd13; req_tag = TAG_W'(4);
    step();
    req_op1 = 32'd17; req_op2 = 32'd19; req_tag = TAG_W'(5);
    step();
    req_valid = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete(); acc_cyc.delete();
    n_chk++; if ({busy, rsp_valid, mul_en} !== 3'b000) begin n_fail++; $display("FAIL midrst_state got busy %b rsp_valid %b mul_en %b want 000", busy, rsp_valid, mul_en); end else n_pass++;
    for (int c = 0; c < 8; c++) step();
    n_chk++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL midrst_ghost got %0d responses want 0", got_q.size()); end else n_pass++;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end else n_pass++;
    got_q.delete(); got_cyc.delete();
    req_valid = 1'b1; req_op1 = 32'd7; req_op2 = 32'd6; req_tag = TAG_W'(6);
    step();
    drain(20, ok);
    n_chk++; if (ok !== 1'b1 || got_q.size() !== 1 || acc_cyc.size() !== 1) begin n_fail++; $display("FAIL midrst_new_count got %0d rsp ok %b want 1", got_q.size(), ok); end else n_pass++;
    if (got_q.size() == 1 && acc_cyc.size() == 1) begin
      n_chk++; if (got_q[0] !== {1'b0, TAG_W'(6), 64'd42}) begin n_fail++; $display("FAIL midrst_new_rsp got %h want 42 tag 6", got_q[0]); end else n_pass++;
      n_chk++; if (got_cyc[0] - acc_cyc[0] !== 2 + LAT) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", got_cyc[0] - acc_cyc[0], 2 + LAT); end else n_pass++;
    end
  endtask

  task automatic test_err();
    bit ok;
    clear_rec();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial got %b want 0", err); end else n_pass++;
    kill_val = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op1 = 32'd2; req_op2 = 32'd3; req_tag = TAG_W'(7);
    step();
    drain(20, ok);
    kill_val = 1'b0;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end else n_pass++;
    n_chk++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL err_rsp_count got %0d want 1", got_q.size()); end else n_pass++;
    req_valid = 1'b1; req_op1 = 32'd4; req_op2 = 32'd4; req_tag = TAG_W'(8);
    step();
    drain(20, ok);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end else n_pass++;
    n_chk++; if (got_q.size() !== 2 || exp_q.size() !== 2) begin n_fail++; $display("FAIL err_total got %0d rsp want 2", got_q.size()); end else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL err_rsp%0d got %h want %h", i, got_q[i], exp_q[i]); end else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_tag = '0; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ovf();
    test_random();
    test_reset_midflight();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
